// File: rtl/comp_div_seq_pkg.sv
// Shared constants and state encoding for the LED ratio divider and its
// LED2 compensation stage.
package comp_div_seq_pkg;
  localparam int DW   = 4;
  localparam int FRAC = 4;
  localparam int QW   = DW + FRAC;

  localparam logic [3:0]    SH_LO  = 4'd3;
  localparam logic [3:0]    SH_HI  = 4'd4;
  localparam logic [QW-1:0] DIV0_Y = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    HOLD
  } state_t;
endpackage

// File: rtl/comp_div_seq_fix.sv
// Leading-one detector plus LED2 discrete correction of a 4.4 quotient.
// Purely combinational so the same block can sit in a non-sequential path.
module comp_fix
  import comp_div_seq_pkg::*;
(
  input  logic [QW-1:0] q,
  input  logic          led2,
  output logic [QW-1:0] y,
  output logic [3:0]    shiftamount
);
  localparam logic [QW-1:0] ONE = 1;

  logic [3:0] s;

  // Ascending scan: the highest set bit is the last one written.
  always_comb begin
    s = '0;
    for (int i = 0; i < QW; i++) begin
      if (q[i]) s = 4'(i);
    end
  end

  always_comb begin
    y           = q;
    shiftamount = s;
    if (led2 && (s == SH_LO)) begin
      y = q - ONE;
    end else if (led2 && (s == SH_HI)) begin
      y           = {q[QW-2:0], 1'b0} - ONE;
      shiftamount = s - 4'd1;
    end
  end
endmodule

// File: rtl/comp_div_seq.sv
// Handshaked restoring divider producing a 4.4 quotient, followed by one
// normalise/compensate cycle and a result hold stage.
module comp_div_seq
  import comp_div_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          led2,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] y,
  output logic [3:0]    shiftamount,
  output logic [QW-1:0] raw_q,
  output logic          div_err,
  output logic          busy
);
  state_t        state_reg, state_next;
  logic [QW-1:0] dvd_reg, dvd_next;
  logic [DW-1:0] dvs_reg, dvs_next;
  logic          led2_reg, led2_next;
  logic [DW-1:0] rem_reg, rem_next;
  logic [QW-1:0] q_reg, q_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [QW-1:0] y_reg, y_next;
  logic [3:0]    sh_reg, sh_next;
  logic [QW-1:0] raw_reg, raw_next;
  logic          err_reg, err_next;

  logic [DW:0]   rem5;
  logic [QW-1:0] fix_y;
  logic [3:0]    fix_sh;

  comp_fix u_fix (
    .q           (q_reg),
    .led2        (led2_reg),
    .y           (fix_y),
    .shiftamount (fix_sh)
  );

  assign rem5 = {rem_reg, dvd_reg[QW-1]};

  always_comb begin
    state_next = state_reg;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    led2_next  = led2_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    y_next     = y_reg;
    sh_next    = sh_reg;
    raw_next   = raw_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          dvd_next  = {d, {FRAC{1'b0}}};
          dvs_next  = e;
          led2_next = led2;
          if (e == '0) begin
            state_next = HOLD;
            y_next     = DIV0_Y;
            raw_next   = '0;
            sh_next    = '0;
            err_next   = 1'b1;
          end else begin
            state_next = DIV;
            cnt_next   = '0;
            rem_next   = '0;
            q_next     = '0;
            err_next   = 1'b0;
          end
        end
      end
      DIV: begin
        dvd_next = {dvd_reg[QW-2:0], 1'b0};
        if (rem5 >= {1'b0, dvs_reg}) begin
          rem_next = DW'(rem5 - {1'b0, dvs_reg});
          q_next   = {q_reg[QW-2:0], 1'b1};
        end else begin
          rem_next = rem5[DW-1:0];
          q_next   = {q_reg[QW-2:0], 1'b0};
        end
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) state_next = NORM;
      end
      NORM: begin
        y_next     = fix_y;
        sh_next    = fix_sh;
        raw_next   = q_reg;
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      led2_reg  <= 1'b0;
      rem_reg   <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      y_reg     <= '0;
      sh_reg    <= '0;
      raw_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dvd_reg   <= dvd_next;
      dvs_reg   <= dvs_next;
      led2_reg  <= led2_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      y_reg     <= y_next;
      sh_reg    <= sh_next;
      raw_reg   <= raw_next;
      err_reg   <= err_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign out_valid   = (state_reg == HOLD);
  assign y           = y_reg;
  assign shiftamount = sh_reg;
  assign raw_q       = raw_reg;
  assign div_err     = err_reg;
endmodule

// File: tb/tb_comp_div_seq.sv
// Directed bench for comp_div_seq: arithmetic reference model, per-cycle
// compare process, and literal expectations for the key vectors.
module tb_comp_div_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       led2 = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] e = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic [3:0] shiftamount;
  logic [7:0] raw_q;
  logic       div_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic       exp_live = 1'b0;
  logic [7:0] exp_y, exp_raw;
  logic [3:0] exp_sh;
  logic       exp_err;

  comp_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .led2        (led2),
    .d           (d),
    .e           (e),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .shiftamount (shiftamount),
    .raw_q       (raw_q),
    .div_err     (div_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: quotient = floor(16*d/e), then compensation by leading-one position.
  task automatic model(input logic [3:0] dd, input logic [3:0] ee, input logic ll,
                       output logic [7:0] my, output logic [7:0] mraw,
                       output logic [3:0] msh, output logic merr);
    int q, s, r;
    if (ee == 0) begin
      my = 8'hFF; mraw = 8'h00; msh = 4'd0; merr = 1'b1;
    end else begin
      q = (int'(dd) * 16) / int'(ee);
      s = 0;
      for (int k = 0; k < 8; k++) if ((q >> k) & 1) s = k;
      r = q;
      if (ll && s == 3) r = q - 1;
      else if (ll && s == 4) begin r = (2 * q - 1) % 256; s = s - 1; end
      my = 8'(r); mraw = 8'(q); msh = 4'(s); merr = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (exp_live && !rst) begin
      check("busy_inflight", 32'(busy), 1);
      if (out_valid) begin
        check("y", 32'(y), 32'(exp_y));
        check("raw_q", 32'(raw_q), 32'(exp_raw));
        check("shiftamount", 32'(shiftamount), 32'(exp_sh));
        check("div_err", 32'(div_err), 32'(exp_err));
        check("in_ready_hold", 32'(in_ready), 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_live = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_raw_q", 32'(raw_q), 0);
    check("rst_sh", 32'(shiftamount), 0);
    check("rst_div_err", 32'(div_err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
  endtask

  task automatic accept(input logic [3:0] dd, input logic [3:0] ee, input logic ll);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1; d = dd; e = ee; led2 = ll;
    @(posedge clk);
    model(dd, ee, ll, exp_y, exp_raw, exp_sh, exp_err);
    exp_live = 1'b1;
    #1;
    in_valid = 1'b0;
    d = 4'($urandom_range(15, 0));
    e = 4'($urandom_range(15, 0));
    led2 = 1'($urandom_range(1, 0));
  endtask

  task automatic wait_valid(input logic [3:0] dd, input logic [3:0] ee, input logic ll,
                            input logic [7:0] ly, input logic [3:0] lsh);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, (ee == 0) ? 1 : 10);
    check("lit_y", 32'(y), 32'(ly));
    check("lit_sh", 32'(shiftamount), 32'(lsh));
    $display("[TB] op d=%0d e=%0d led2=%0d -> y=%0d raw_q=%0d sh=%0d err=%0d lat=%0d",
             dd, ee, ll, y, raw_q, shiftamount, div_err, lat);
  endtask

  task automatic release_op(input int hold);
    if (hold > 0) begin
      in_valid = 1'b1; d = 4'd15; e = 4'd3; led2 = 1'b1;
      repeat (hold) @(negedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    exp_live = 1'b0;
    check("hs_out_valid", 32'(out_valid), 0);
    check("hs_in_ready", 32'(in_ready), 1);
  endtask

  task automatic op(input logic [3:0] dd, input logic [3:0] ee, input logic ll,
                    input logic [7:0] ly, input logic [3:0] lsh, input int hold);
    accept(dd, ee, ll);
    wait_valid(dd, ee, ll, ly, lsh);
    release_op(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] my, mraw;
    logic [3:0] msh;
    logic       merr;

    model(4'd9, 4'd1, 1'b0, my, mraw, msh, merr);
    check("model_9_1_y", 32'(my), 144);
    check("model_9_1_sh", 32'(msh), 7);
    model(4'd1, 4'd2, 1'b1, my, mraw, msh, merr);
    check("model_1_2_y", 32'(my), 7);
    model(4'd3, 4'd2, 1'b1, my, mraw, msh, merr);
    check("model_3_2_y", 32'(my), 47);
    check("model_3_2_raw", 32'(mraw), 24);
    model(4'd5, 4'd0, 1'b0, my, mraw, msh, merr);
    check("model_div0_err", 32'(merr), 1);

    do_reset();

    op(4'd9,  4'd1,  1'b0, 8'd144, 4'd7, 0);
    op(4'd1,  4'd2,  1'b1, 8'd7,   4'd3, 0);
    op(4'd1,  4'd2,  1'b0, 8'd8,   4'd3, 0);
    op(4'd1,  4'd1,  1'b1, 8'd31,  4'd3, 0);
    op(4'd3,  4'd2,  1'b1, 8'd47,  4'd3, 0);
    op(4'd5,  4'd0,  1'b0, 8'hFF,  4'd0, 0);
    op(4'd15, 4'd15, 1'b1, 8'd31,  4'd3, 0);
    op(4'd7,  4'd3,  1'b1, 8'd37,  4'd5, 0);
    op(4'd0,  4'd5,  1'b1, 8'd0,   4'd0, 0);
    op(4'd2,  4'd3,  1'b1, 8'd9,   4'd3, 5);

    // Abort mid-division, then a clean run.
    accept(4'd7, 4'd1, 1'b1);
    repeat (4) @(posedge clk);
    do_reset();
    op(4'd15, 4'd1, 1'b0, 8'd240, 4'd7, 0);

    // Abort while a result is being held.
    accept(4'd4, 4'd1, 1'b0);
    wait_valid(4'd4, 4'd1, 1'b0, 8'd64, 4'd6);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
